// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the fetch-side program counter unit.
package program_counter_unit_pkg;

    typedef enum logic [1:0] {PC_IDLE, PC_RUN, PC_HALT} pc_state_t;

    localparam logic [1:0] kPCSelNone = 2'b00;
    localparam logic [1:0] kPCSel1    = 2'b01;
    localparam logic [1:0] kPCSel2    = 2'b10;
    localparam logic [1:0] kPCSel3    = 2'b11;

endpackage

// File: rtl/program_counter_unit_link_regs.sv
// Three link registers with one write port, one combinational read port and a bulk clear.
module pc_link_regs
    import program_counter_unit_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            we,
    input  logic [1:0]      wr_sel,
    input  logic [PC_W-1:0] wr_data,
    input  logic [1:0]      rd_sel,
    output logic [PC_W-1:0] rd_data
);

    logic [2:0][PC_W-1:0] link_q, link_d;

    always_comb begin
        link_d = link_q;
        if (clr) begin
            link_d = '0;
        end else if (we) begin
            case (wr_sel)
                kPCSel1: link_d[0] = wr_data;
                kPCSel2: link_d[1] = wr_data;
                kPCSel3: link_d[2] = wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) link_q <= '0;
        else        link_q <= link_d;
    end

    always_comb begin
        case (rd_sel)
            kPCSel1: rd_data = link_q[0];
            kPCSel2: rd_data = link_q[1];
            kPCSel3: rd_data = link_q[2];
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter sequencer: IDLE/RUN/HALT FSM, next-PC mux, zero flag and run-cycle counter.
module program_counter_unit
    import program_counter_unit_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int SPC_OFFSET = 2,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic             Ack,
    input  logic             ZeroIn,
    input  logic             FlagWrEn,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Zero,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    pc_state_t        state_q, state_d;
    logic             start_q;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             link_we, link_clr;
    logic [PC_W-1:0]  link_rd, spc_data;
    logic             jump_taken, is_spc;

    // Branches use the flag as registered before this edge, never ZeroIn.
    assign jump_taken = (PCRegSelect != kPCSelNone) &&
                        ((JumpEqual && zero_q) || (JumpNotEqual && !zero_q));
    assign is_spc     = (PCRegSelect != kPCSelNone) && !JumpEqual && !JumpNotEqual;
    assign spc_data   = pc_q + (OffsetEn ? PC_W'(SPC_OFFSET) : PC_W'(1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        link_we  = 1'b0;
        link_clr = 1'b0;
        case (state_q)
            PC_IDLE: begin
                pc_d = '0;
                if (!Start && start_q) state_d = PC_RUN;
            end
            PC_RUN: begin
                if (Start) begin
                    state_d  = PC_IDLE;
                    pc_d     = '0;
                    zero_d   = 1'b0;
                    cnt_d    = '0;
                    link_clr = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (Ack) begin
                        state_d = PC_HALT;
                    end else begin
                        pc_d    = jump_taken ? link_rd : pc_q + 1'b1;
                        link_we = is_spc;
                        if (FlagWrEn) zero_d = ZeroIn;
                    end
                end
            end
            PC_HALT: begin
                if (Start) begin
                    state_d  = PC_IDLE;
                    pc_d     = '0;
                    zero_d   = 1'b0;
                    cnt_d    = '0;
                    link_clr = 1'b1;
                end
            end
            default: state_d = PC_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= PC_IDLE;
            start_q <= 1'b0;
            pc_q    <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= Start;
            pc_q    <= pc_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    pc_link_regs #(.PC_W(PC_W)) u_link_regs (
        .clk     (Clk),
        .rst_n   (Reset),
        .clr     (link_clr),
        .we      (link_we),
        .wr_sel  (PCRegSelect),
        .wr_data (spc_data),
        .rd_sel  (PCRegSelect),
        .rd_data (link_rd)
    );

    assign ProgCtr    = pc_q;
    assign Zero       = zero_q;
    assign Done       = (state_q == PC_HALT);
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares DUT outputs.
module tb_program_counter_unit;

    localparam int PC_W    = 10;
    localparam int CNT_W   = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0, JumpEqual = 1'b0, JumpNotEqual = 1'b0, OffsetEn = 1'b0;
    logic [1:0]       PCRegSelect = 2'b00;
    logic             Ack = 1'b0, ZeroIn = 1'b0, FlagWrEn = 1'b0;
    logic [PC_W-1:0]  ProgCtr;
    logic             Zero, Done;
    logic [CNT_W-1:0] CycleCount;

    program_counter_unit #(.PC_W(PC_W), .SPC_OFFSET(2), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
        .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn), .PCRegSelect(PCRegSelect),
        .Ack(Ack), .ZeroIn(ZeroIn), .FlagWrEn(FlagWrEn), .ProgCtr(ProgCtr),
        .Zero(Zero), .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int    pc;
        bit    zero;
        bit    done;
        int    cnt;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: plain integers, mode flags, link array indexed by select.
    int m_pc, m_cnt;
    bit m_zero, m_run, m_halt, m_sp;
    int m_link[4];

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_zero = 0; m_run = 0; m_halt = 0; m_sp = 0;
        m_link = '{default: 0};
    endtask

    task automatic model_step(bit st, bit je, bit jne, bit off, bit [1:0] sel,
                              bit ak, bit zi, bit fw);
        int nxt;
        if (st) begin
            if (m_run || m_halt) begin
                m_pc = 0; m_zero = 0; m_cnt = 0; m_link = '{default: 0};
            end
            m_run = 0; m_halt = 0;
        end else if (!m_run && !m_halt) begin
            if (m_sp) m_run = 1;
        end else if (m_run) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (ak) begin
                m_run = 0; m_halt = 1;
            end else begin
                if (sel != 0 && ((je && m_zero) || (jne && !m_zero))) nxt = m_link[sel];
                else nxt = (m_pc + 1) % PC_MOD;
                if (sel != 0 && !je && !jne) m_link[sel] = (m_pc + (off ? 2 : 1)) % PC_MOD;
                if (fw) m_zero = zi;
                m_pc = nxt;
            end
        end
        m_sp = st;
    endtask

    task automatic push_exp(string tag);
        exp_t e;
        e.pc = m_pc; e.zero = m_zero; e.done = m_halt; e.cnt = m_cnt; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: runs after each falling clock edge and right after an async reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk or negedge Reset);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (int'(ProgCtr) != e.pc || Zero !== e.zero || Done !== e.done ||
                    int'(CycleCount) != e.cnt) begin
                    errors++;
                    $display("FAIL %s: got pc=%03h zero=%b done=%b cnt=%0d, want pc=%03h zero=%b done=%b cnt=%0d",
                             e.tag, ProgCtr, Zero, Done, CycleCount, e.pc[PC_W-1:0], e.zero,
                             e.done, e.cnt);
                end
            end
        end
    end

    task automatic step(bit st, bit je, bit jne, bit off, bit [1:0] sel,
                        bit ak, bit zi, bit fw, string tag);
        @(negedge Clk);
        #2;
        Start = st; JumpEqual = je; JumpNotEqual = jne; OffsetEn = off;
        PCRegSelect = sel; Ack = ak; ZeroIn = zi; FlagWrEn = fw;
        model_step(st, je, jne, off, sel, ak, zi, fw);
        @(posedge Clk);
        #1;
        push_exp(tag);
    endtask

    task automatic plain(string tag);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, tag);
    endtask

    task automatic start_run();
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, "start_hi1");
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, "start_hi2");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, "start_fall");
    endtask

    task automatic run_to(int target);
        int guard = 0;
        while (m_pc != target && m_run && guard < 2000) begin
            plain("run_to");
            guard++;
        end
        checks++;
        if (m_pc != target || !m_run) begin
            errors++;
            $display("FAIL run_to: model pc=%0h run=%0b, want pc=%0h in run", m_pc, m_run, target);
        end
    endtask

    task automatic async_reset();
        @(negedge Clk);
        #2;
        Start = 0; JumpEqual = 0; JumpNotEqual = 0; OffsetEn = 0;
        PCRegSelect = 0; Ack = 0; ZeroIn = 0; FlagWrEn = 0;
        model_reset();
        push_exp("async_reset");
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
    endtask

    initial begin
        int guard;
        bit st, je, jne, off, ak, zi, fw;
        bit [1:0] sel;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        push_exp("reset_state");
        @(negedge Clk);
        #2;
        Reset = 1'b1;

        // Start pulse then five straight-line instructions.
        start_run();
        repeat (5) plain("seq5");

        // Async reset mid-run; counter has saturated by then.
        run_to('h025);
        async_reset();

        // Link regs must read back zero after reset: jne via PCreg3 lands on 0.
        start_run();
        step(0, 0, 1, 0, 2'b11, 0, 0, 0, "jne_cleared_link");
        run_to('h010);
        step(0, 0, 0, 1, 2'b10, 0, 0, 0, "spc_sel2_off");
        run_to('h018);
        step(0, 0, 0, 0, 2'b00, 0, 1, 1, "flag_set");
        run_to('h01A);
        step(0, 0, 0, 0, 2'b01, 0, 0, 0, "spc_sel1");
        run_to('h020);
        step(0, 1, 0, 0, 2'b10, 0, 0, 0, "je_taken");
        step(0, 0, 1, 0, 2'b01, 0, 0, 0, "jne_not_taken");
        step(0, 0, 0, 0, 2'b00, 0, 0, 1, "flag_clear");
        step(0, 0, 1, 0, 2'b01, 0, 0, 0, "jne_taken");

        // Halt, frozen state, strobes ignored, then Start returns to IDLE.
        run_to('h07F);
        step(0, 0, 0, 0, 2'b00, 1, 1, 1, "ack");
        step(0, 1, 1, 1, 2'b01, 0, 1, 1, "halt_hold1");
        step(0, 0, 0, 0, 2'b10, 0, 0, 0, "halt_hold2");
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, "halt_to_idle");
        step(0, 1, 0, 0, 2'b11, 0, 1, 1, "idle_restart");

        // PC wrap at the top of the ROM.
        run_to('h3FE);
        repeat (3) plain("wrap");

        // Randomised traffic across all states.
        for (int i = 0; i < 1500; i++) begin
            if (m_run) begin
                st  = ($urandom % 64) == 0;
                ak  = ($urandom % 50) == 0;
            end else begin
                st  = ($urandom % 4) == 0;
                ak  = $urandom % 2;
            end
            je  = ($urandom % 5) == 0;
            jne = ($urandom % 5) == 0;
            off = $urandom % 2;
            sel = 2'($urandom % 4);
            zi  = $urandom % 2;
            fw  = ($urandom % 3) == 0;
            step(st, je, jne, off, sel, ak, zi, fw, "random");
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge Clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
